ahb_s2m_ds: RTL
===============

Name: ahb_s2m_ds

Overview:
AHB slave-to-master return-path multiplexer with an integrated default slave. It is the response-direction counterpart of the master-to-slave address/write-data mux. It registers the decoder's slave select at each address phase and steers HRDATA/HREADY/HRESP from the selected slave back to all masters during the following data phase. Active transfers that hit no slave are answered by the default slave with the standard two-cycle ERROR response.

Parameters:
NUM_SLAVE, 3, number of real slave ports; fixed at 3 in this revision, and the port list matches it.
DEFAULT_RDATA, 32'h0, HRDATA driven when the default slave or no slave owns the data phase.
ERRCNT_W, 8, width of the saturating error-response counter.

Ports:
HCLK  input  1  bus clock
HRESETn  input  1  asynchronous active-low reset
HTRANS  input  2  muxed master HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
HSEL_0, HSEL_1, HSEL_2  input  1 each  address-phase slave selects from decoder
HRDATA_0, HRDATA_1, HRDATA_2  input  32 each  slave read data
HREADY_0, HREADY_1, HREADY_2  input  1 each  slave HREADYout
HRESP_0, HRESP_1, HRESP_2  input  2 each  slave response (OKAY=0, ERROR=1, RETRY=2, SPLIT=3)
HREADY  output  1  muxed ready, broadcast to masters and fed back to all slaves
HRDATA  output  32  muxed read data
HRESP  output  2  muxed response
ERR_CNT  output  ERRCNT_W  count of default-slave ERROR responses, saturating
MULTI_SEL  output  1  sticky flag: more than one HSEL was sampled high at an address phase

Behaviour:
- Reset (HRESETn=0, asynchronous):
  - data-phase select = NONE; default-slave FSM = IDLE; ERR_CNT=0; MULTI_SEL=0.
  - Outputs: HREADY=1, HRESP=OKAY, HRDATA=DEFAULT_RDATA.
- Data-phase select register (dsel, encodings NONE/S0/S1/S2/DEF):
  - Updates only on posedge HCLK with HREADY=1.
  - Loads Sk for the lowest index k with HSEL_k=1.
  - Otherwise loads DEF if HTRANS is NONSEQ or SEQ, else NONE.
  - Holds its value while HREADY=0.
- MULTI_SEL: set at the same sample point when two or more HSEL are high. Cleared only by reset.
- Output mux (combinational from dsel):
  - Sk: HRDATA=HRDATA_k, HREADY=HREADY_k, HRESP=HRESP_k.
  - NONE: HREADY=1, HRESP=OKAY, HRDATA=DEFAULT_RDATA.
  - DEF: HRDATA=DEFAULT_RDATA; HREADY/HRESP come from the default-slave FSM.
- Default-slave FSM (states IDLE, ERR1, ERR2):
  - IDLE: on posedge with HREADY=1 and an unmapped active transfer (no HSEL, HTRANS NONSEQ/SEQ) -> ERR1.
  - ERR1: drives HREADY=0, HRESP=ERROR. Unconditionally -> ERR2 next cycle.
  - ERR2: drives HREADY=1, HRESP=ERROR. ERR_CNT increments (saturating at all-ones) on entry to ERR2.
    - Another unmapped active transfer sampled at this edge -> ERR1.
    - Otherwise -> IDLE.
  - Result: each unmapped NONSEQ/SEQ gets exactly one wait cycle plus one ERROR completion cycle.
  - Unmapped IDLE/BUSY transfers load NONE and complete zero-wait OKAY.
- Pass-through: slave responses (wait states, two-cycle ERROR/RETRY/SPLIT) are forwarded unmodified, with no added latency. HREADY is purely combinational from dsel plus FSM state.
- Back-to-back transfers:
  - Address phase of transfer N+1 overlaps data phase of N; dsel switches only at the HREADY=1 edge closing N.
  - Transition from slave k to the default slave, or the reverse, needs no idle cycle.
- Reset mid-operation (e.g. in ERR1 or during a slave wait state): all state returns to reset values immediately; HREADY=1 in the same cycle.

Test Plan:
- Reset, then IDLE transfers only -> HREADY=1, HRESP=0, HRDATA=32'h0, ERR_CNT=0.
- NONSEQ with HSEL_1=1, HREADY_1 low 2 cycles then high, HRDATA_1=32'hCAFE_0001 -> next data phase HREADY low 2 cycles, then HRDATA=32'hCAFE_0001, HRESP=OKAY; HSEL changes during the wait are ignored.
- NONSEQ with no HSEL -> next cycle HREADY=0/HRESP=1, following cycle HREADY=1/HRESP=1, ERR_CNT=1; then IDLE -> OKAY.
- Two back-to-back unmapped SEQ, then S2 transfer -> ERR1,ERR2,ERR1,ERR2 sequence, ERR_CNT=2, then HRDATA_2 returned with no gap.
- HSEL_0=HSEL_2=1 simultaneously -> S0 data returned, MULTI_SEL=1 and remains 1 after subsequent clean transfers.
- Assert HRESETn=0 during ERR1 -> HREADY=1, HRESP=0 immediately; ERR_CNT=0; with ERRCNT_W=2, four errors -> ERR_CNT saturates at 3.

Source files
------------

// File: rtl/ahb_s2m_ds_if.sv
// ---------------------------------------------------------------------------
// ahb_s2m_ds_if
// Bus bundle for the AHB slave-to-master return-path multiplexer.
//   Request side  : HTRANS (muxed master transfer type), HSEL_0..2 (decoder)
//   Slave returns : HRDATA_k, HREADY_k, HRESP_k for k = 0..2
//   Muxed returns : HREADY, HRDATA, HRESP broadcast back to the masters
//   Status        : ERR_CNT (default-slave ERROR count), MULTI_SEL (sticky)
// Modports:
//   slave  - view taken by the return-path mux itself
//   master - view taken by whatever drives the bus (masters/decoder/slaves)
// ---------------------------------------------------------------------------
interface ahb_s2m_ds_if #(
    parameter int ERRCNT_W = 8
);
    logic [1:0]          HTRANS;
    logic                HSEL_0;
    logic                HSEL_1;
    logic                HSEL_2;
    logic [31:0]         HRDATA_0;
    logic [31:0]         HRDATA_1;
    logic [31:0]         HRDATA_2;
    logic                HREADY_0;
    logic                HREADY_1;
    logic                HREADY_2;
    logic [1:0]          HRESP_0;
    logic [1:0]          HRESP_1;
    logic [1:0]          HRESP_2;
    logic                HREADY;
    logic [31:0]         HRDATA;
    logic [1:0]          HRESP;
    logic [ERRCNT_W-1:0] ERR_CNT;
    logic                MULTI_SEL;

    modport slave (
        input  HTRANS, HSEL_0, HSEL_1, HSEL_2,
        input  HRDATA_0, HRDATA_1, HRDATA_2,
        input  HREADY_0, HREADY_1, HREADY_2,
        input  HRESP_0, HRESP_1, HRESP_2,
        output HREADY, HRDATA, HRESP, ERR_CNT, MULTI_SEL
    );

    modport master (
        output HTRANS, HSEL_0, HSEL_1, HSEL_2,
        output HRDATA_0, HRDATA_1, HRDATA_2,
        output HREADY_0, HREADY_1, HREADY_2,
        output HRESP_0, HRESP_1, HRESP_2,
        input  HREADY, HRDATA, HRESP, ERR_CNT, MULTI_SEL
    );
endinterface

// File: rtl/ahb_s2m_ds.sv
// ---------------------------------------------------------------------------
// ahb_s2m_ds
// AHB slave-to-master return-path multiplexer with an integrated default
// slave. The decoder's slave select is captured at every address phase
// (HREADY=1 edge) and steers HRDATA/HREADY/HRESP of that slave back to the
// masters during the following data phase. Active transfers that hit no
// slave are answered with a two-cycle ERROR by the internal default slave.
// Ports:
//   HCLK     - bus clock
//   HRESETn  - asynchronous active-low reset
//   bus      - ahb_s2m_ds_if.slave bundle (requests, slave returns,
//              muxed returns, ERR_CNT, MULTI_SEL)
// ---------------------------------------------------------------------------
module ahb_s2m_ds #(
    parameter int          NUM_SLAVE     = 3,
    parameter logic [31:0] DEFAULT_RDATA = 32'h0000_0000,
    parameter int          ERRCNT_W      = 8
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    ahb_s2m_ds_if.slave   bus
);

    localparam logic [1:0] RESP_OKAY  = 2'd0;
    localparam logic [1:0] RESP_ERROR = 2'd1;

    typedef enum logic [2:0] {
        DSEL_NONE = 3'd0,
        DSEL_S0   = 3'd1,
        DSEL_S1   = 3'd2,
        DSEL_S2   = 3'd3,
        DSEL_DEF  = 3'd4
    } dsel_t;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    dsel_t                r_dsel;
    ds_state_t            r_ds_state;
    logic                 r_def_hready;
    logic [1:0]           r_def_hresp;
    logic [ERRCNT_W-1:0]  r_err_cnt;
    logic                 r_multi_sel;

    logic [NUM_SLAVE-1:0] w_hsel;
    logic                 w_active;
    logic                 w_multi;
    logic                 w_unmapped;
    dsel_t                w_dsel_nxt;
    logic                 w_hready;
    logic [1:0]           w_hresp;
    logic [31:0]          w_hrdata;

    assign w_hsel     = {bus.HSEL_2, bus.HSEL_1, bus.HSEL_0};
    // NONSEQ (2) and SEQ (3) are the only transfer types with HTRANS[1] set.
    assign w_active   = bus.HTRANS[1];
    assign w_multi    = (w_hsel[0] & w_hsel[1]) | (w_hsel[0] & w_hsel[2]) |
                        (w_hsel[1] & w_hsel[2]);
    assign w_unmapped = (w_hsel == {NUM_SLAVE{1'b0}}) && w_active;

    // Next data-phase owner: lowest-index select wins, else default slave
    // for active transfers, else nobody.
    always_comb begin
        w_dsel_nxt = DSEL_NONE;
        if (w_hsel[0]) begin
            w_dsel_nxt = DSEL_S0;
        end else if (w_hsel[1]) begin
            w_dsel_nxt = DSEL_S1;
        end else if (w_hsel[2]) begin
            w_dsel_nxt = DSEL_S2;
        end else if (w_active) begin
            w_dsel_nxt = DSEL_DEF;
        end else begin
            w_dsel_nxt = DSEL_NONE;
        end
    end

    // Data-phase select and sticky multi-select flag, sampled at address phases.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_dsel      <= DSEL_NONE;
            r_multi_sel <= 1'b0;
        end else if (w_hready) begin
            r_dsel      <= w_dsel_nxt;
            r_multi_sel <= r_multi_sel | w_multi;
        end else begin
            r_dsel      <= r_dsel;
            r_multi_sel <= r_multi_sel;
        end
    end

    // Default-slave FSM with registered HREADY/HRESP and the error counter.
    // ERR states are only reachable while r_dsel is DEF, so the FSM's own
    // ready output is what gates sampling during ERR1/ERR2.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_ds_state   <= DS_IDLE;
            r_def_hready <= 1'b1;
            r_def_hresp  <= RESP_OKAY;
            r_err_cnt    <= {ERRCNT_W{1'b0}};
        end else begin
            case (r_ds_state)
                DS_IDLE: begin
                    if (w_hready && w_unmapped) begin
                        r_ds_state   <= DS_ERR1;
                        r_def_hready <= 1'b0;
                        r_def_hresp  <= RESP_ERROR;
                    end else begin
                        r_ds_state   <= DS_IDLE;
                        r_def_hready <= 1'b1;
                        r_def_hresp  <= RESP_OKAY;
                    end
                end
                DS_ERR1: begin
                    r_ds_state   <= DS_ERR2;
                    r_def_hready <= 1'b1;
                    r_def_hresp  <= RESP_ERROR;
                    if (r_err_cnt != {ERRCNT_W{1'b1}}) begin
                        r_err_cnt <= r_err_cnt + ERRCNT_W'(1);
                    end else begin
                        r_err_cnt <= r_err_cnt;
                    end
                end
                DS_ERR2: begin
                    if (w_hready && w_unmapped) begin
                        r_ds_state   <= DS_ERR1;
                        r_def_hready <= 1'b0;
                        r_def_hresp  <= RESP_ERROR;
                    end else begin
                        r_ds_state   <= DS_IDLE;
                        r_def_hready <= 1'b1;
                        r_def_hresp  <= RESP_OKAY;
                    end
                end
                default: begin
                    r_ds_state   <= DS_IDLE;
                    r_def_hready <= 1'b1;
                    r_def_hresp  <= RESP_OKAY;
                end
            endcase
        end
    end

    // Return-path mux: zero-latency forwarding of the data-phase owner.
    always_comb begin
        w_hready = 1'b1;
        w_hresp  = RESP_OKAY;
        w_hrdata = DEFAULT_RDATA;
        case (r_dsel)
            DSEL_S0: begin
                w_hready = bus.HREADY_0;
                w_hresp  = bus.HRESP_0;
                w_hrdata = bus.HRDATA_0;
            end
            DSEL_S1: begin
                w_hready = bus.HREADY_1;
                w_hresp  = bus.HRESP_1;
                w_hrdata = bus.HRDATA_1;
            end
            DSEL_S2: begin
                w_hready = bus.HREADY_2;
                w_hresp  = bus.HRESP_2;
                w_hrdata = bus.HRDATA_2;
            end
            DSEL_DEF: begin
                w_hready = r_def_hready;
                w_hresp  = r_def_hresp;
                w_hrdata = DEFAULT_RDATA;
            end
            DSEL_NONE: begin
                w_hready = 1'b1;
                w_hresp  = RESP_OKAY;
                w_hrdata = DEFAULT_RDATA;
            end
            default: begin
                w_hready = 1'b1;
                w_hresp  = RESP_OKAY;
                w_hrdata = DEFAULT_RDATA;
            end
        endcase
    end

    assign bus.HREADY    = w_hready;
    assign bus.HRESP     = w_hresp;
    assign bus.HRDATA    = w_hrdata;
    assign bus.ERR_CNT   = r_err_cnt;
    assign bus.MULTI_SEL = r_multi_sel;

endmodule
